frame_loader: RTL and testbench
===============================

// Module: frame_loader
// PURPOSE
//   Upstream input stage of the conv accelerator. Accepts a raster-order byte stream with
//   valid/ready, assembles a complete ROWS x COLS 8-bit frame and presents it in parallel
//   with a valid/ready handshake. The parallel frame drives the accelerator's frame input,
//   which is handed to the im2col stage.
// PARAMETERS
//   ROWS  28  frame height in pixels
//   COLS  28  frame width in pixels
//   DW     8  pixel width in bits
// PORTS
//   i_clk         in   1               clock; all logic on the rising edge
//   i_rst         in   1               synchronous reset, active-high
//   i_pix_valid   in   1               pixel stream valid
//   o_pix_ready   out  1               pixel stream ready
//   i_pix_data    in   DW              pixel value, row-major raster order
//   i_pix_last    in   1               end-of-frame marker on the final pixel
//   o_post_valid  out  1               assembled frame valid
//   i_post_ready  in   1               downstream ready
//   o_data        out  [ROWS][COLS]xDW assembled frame; o_data[r][c] = pixel r*COLS+c
//   o_frame_err   out  1               1-cycle pulse on a framing error
// BEHAVIOUR
//   - Reset values: o_post_valid=0, o_frame_err=0, o_data all 0, row/col counters 0,
//     state FILL. o_pix_ready=0 while i_rst=1.
//   - A pixel is accepted on a cycle where i_pix_valid && o_pix_ready.
//   - Pixel index k writes buffer[row][col], with row=k/COLS and col=k%COLS.
//   - Counters: col increments per accepted pixel and wraps to 0 at COLS-1. row increments
//     on col wrap. Counters use separate row/col registers, not a divide.
//   - FSM states:
//     - FILL: o_pix_ready=1. Accepting pixel ROWS*COLS-1 -> HOLD. The frame becomes visible
//       next cycle: o_post_valid=1, o_data stable.
//     - HOLD: o_pix_ready=0. o_post_valid=1. o_data and o_post_valid stay stable while
//       !i_post_ready. On i_post_ready: o_post_valid=0 next cycle, counters=0, -> FILL.
//   - Latency: o_post_valid rises 1 cycle after the last pixel is accepted.
//   - Framing errors:
//     - i_pix_last=1 on an accepted pixel with k<ROWS*COLS-1: pixel discarded, counters=0,
//       o_frame_err pulses next cycle, stay in FILL. The partial frame is never presented.
//     - i_pix_last=0 on the final pixel (k=ROWS*COLS-1): frame delivered normally and
//       o_frame_err pulses next cycle.
//   - Pixels are not written into o_data registers while o_post_valid=1.
//   - Reset mid-frame or mid-HOLD: all state returns to reset values next cycle. The
//     partial or held frame is lost. No o_frame_err pulse.
// CONFIGURATION
//   PING_PONG_EN
//     - Defined: two frame buffers. Filling buffer B continues while buffer A is held.
//       - B completes while A is still unconsumed: o_pix_ready=0 until the A handshake.
//         B is presented the cycle after that handshake.
//       - B completes in the same cycle A handshakes: B is presented the next cycle with
//         no bubble, and o_pix_ready stays 1.
//       - Steady state: one frame per ROWS*COLS accepted pixels.
//       - Frames are presented in arrival order; the error rules apply per buffer.
//     - Undefined: single buffer, FSM as above. Input stalls for the whole HOLD period.
// TESTING
//   1. Reset, stream pixels 0..783 (value=k mod 256, last on k=783), i_post_ready=1
//      -> o_post_valid for 1 cycle, 1 cycle after k=783 accepted; o_data[1][0]=28;
//      o_data[27][27]=15.
//   2. As 1 with i_post_ready=0 for 50 cycles -> o_post_valid held, o_data unchanged,
//      o_pix_ready=0 throughout (no PING_PONG_EN).
//   3. i_pix_last on k=100 -> o_frame_err=1 for 1 cycle, no o_post_valid. A following
//      full frame is delivered correctly, starting at o_data[0][0].
//   4. Final pixel without i_pix_last -> frame delivered and o_frame_err pulses together
//      with o_post_valid rising.
//   5. i_rst=1 at k=400, then a full frame -> the delivered frame contains only
//      post-reset pixels.
//   6. PING_PONG_EN, back-to-back frames with i_pix_valid=1 and i_post_ready=1
//      -> o_pix_ready never drops; consecutive o_post_valid pulses 784 cycles apart.

Source files
------------

// File: rtl/frame_loader_if.sv
// Pixel-stream in / parallel-frame out bundle for frame_loader.
// slave: loader side; master: upstream source + downstream sink side.
interface frame_loader_if #(
  parameter int ROWS = 28,
  parameter int COLS = 28,
  parameter int DW   = 8
);
  logic                              i_pix_valid;
  logic                              o_pix_ready;
  logic [DW-1:0]                     i_pix_data;
  logic                              i_pix_last;
  logic                              o_post_valid;
  logic                              i_post_ready;
  logic [ROWS-1:0][COLS-1:0][DW-1:0] o_data;
  logic                              o_frame_err;

  modport slave (
    input  i_pix_valid, i_pix_data, i_pix_last, i_post_ready,
    output o_pix_ready, o_post_valid, o_data, o_frame_err
  );

  modport master (
    output i_pix_valid, i_pix_data, i_pix_last, i_post_ready,
    input  o_pix_ready, o_post_valid, o_data, o_frame_err
  );
endinterface

// File: rtl/frame_loader.sv
// Raster byte stream -> parallel ROWS x COLS frame with valid/ready.
// Ports: i_clk, i_rst (sync, high), bus (frame_loader_if.slave).
// Optional PING_PONG_EN: second buffer so filling overlaps holding.
module frame_loader #(
  parameter int ROWS = 28,
  parameter int COLS = 28,
  parameter int DW   = 8
) (
  input logic        i_clk,
  input logic        i_rst,
  frame_loader_if.slave bus
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

  typedef logic [ROWS-1:0][COLS-1:0][DW-1:0] frame_t;

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          err_q, err_d;
  logic          pix_ready;
  logic          accept, at_end, early, wr_en, done;

  assign accept = bus.i_pix_valid && pix_ready;
  assign at_end = (row_q == ROW_MAX) && (col_q == COL_MAX);
  // An early end marker throws the pixel away and restarts the frame.
  assign early  = accept && bus.i_pix_last && !at_end;
  assign wr_en  = accept && !early;
  assign done   = wr_en && at_end;

  assign bus.o_pix_ready = pix_ready;
  assign bus.o_frame_err = err_q;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    err_d = early || (done && !bus.i_pix_last);
    if (early) begin
      row_d = '0;
      col_d = '0;
    end else if (accept) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      row_q <= '0;
      col_q <= '0;
      err_q <= 1'b0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      err_q <= err_d;
    end
  end

`ifdef PING_PONG_EN
  frame_t [1:0] buf_q, buf_d;
  logic   [1:0] full_q, full_d;
  logic         wr_q, wr_d;
  logic         rd_q, rd_d;

  // Stall only when the buffer we would fill still holds a frame.
  assign pix_ready        = !i_rst && !full_q[wr_q];
  assign bus.o_post_valid = full_q[rd_q];
  assign bus.o_data       = buf_q[rd_q];

  always_comb begin
    buf_d  = buf_q;
    full_d = full_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    if (full_q[rd_q] && bus.i_post_ready) begin
      full_d[rd_q] = 1'b0;
      rd_d         = !rd_q;
    end
    if (wr_en) buf_d[wr_q][row_q][col_q] = bus.i_pix_data;
    if (done) begin
      full_d[wr_q] = 1'b1;
      wr_d         = !wr_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      buf_q  <= '0;
      full_q <= '0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      full_q <= full_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
    end
  end
`else
  typedef enum logic {FILL, HOLD} state_e;

  state_e state_q, state_d;
  frame_t buf_q, buf_d;
  logic   pv_q, pv_d;

  assign pix_ready        = !i_rst && (state_q == FILL);
  assign bus.o_post_valid = pv_q;
  assign bus.o_data       = buf_q;

  always_comb begin
    state_d = state_q;
    pv_d    = pv_q;
    buf_d   = buf_q;
    unique case (state_q)
      FILL: begin
        if (wr_en) buf_d[row_q][col_q] = bus.i_pix_data;
        if (done) begin
          state_d = HOLD;
          pv_d    = 1'b1;
        end
      end
      HOLD: begin
        if (bus.i_post_ready) begin
          state_d = FILL;
          pv_d    = 1'b0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= FILL;
      buf_q   <= '0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      pv_q    <= pv_d;
    end
  end
`endif
endmodule

// File: tb/tb_frame_loader.sv
// Self-checking bench for frame_loader.
// Scoreboard of expected frames vs frames seen on the output handshake.
module tb_frame_loader;
  localparam int ROWS  = 28;
  localparam int COLS  = 28;
  localparam int DW    = 8;
  localparam int NPIX  = ROWS * COLS;
  localparam int BOUND = 3000;

  typedef logic [ROWS-1:0][COLS-1:0][DW-1:0] frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frame_loader_if #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) bus ();

  frame_loader #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus.slave)
  );

  int     checks = 0;
  int     errors = 0;
  frame_t exp_q[$];
  frame_t got_q[$];
  int     rise_q[$];
  int     cyc = 0;
  int     pv_cnt = 0;
  int     err_cnt = 0;
  int     err_cyc = -1;
  int     stall_cnt = 0;
  int     acc_cyc = 0;
  logic   prev_pv = 1'b0;
  bit     abort = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (bus.o_post_valid) pv_cnt++;
    if (bus.o_post_valid && !prev_pv) rise_q.push_back(cyc);
    prev_pv = bus.o_post_valid;
    if (bus.o_frame_err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (!rst && bus.i_pix_valid && !bus.o_pix_ready) stall_cnt++;
    if (bus.o_post_valid && bus.i_post_ready) got_q.push_back(bus.o_data);
  end

  function automatic frame_t mk(input int base);
    frame_t f;
    f = '0;
    for (int k = 0; k < NPIX; k++) f[k/COLS][k%COLS] = 8'((base + k) % 256);
    return f;
  endfunction

  function automatic int first_diff(input frame_t a, input frame_t b);
    for (int k = 0; k < NPIX; k++)
      if (a[k/COLS][k%COLS] !== b[k/COLS][k%COLS]) return k;
    return -1;
  endfunction

  task automatic clear_mon();
    pv_cnt = 0;
    err_cnt = 0;
    err_cyc = -1;
    stall_cnt = 0;
    rise_q.delete();
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic send_frame(input int n, input int last_k, input int base);
    int w;
    for (int k = 0; k < n; k++) begin
      if (abort) break;
      bus.i_pix_valid = 1'b1;
      bus.i_pix_data  = 8'((base + k) % 256);
      bus.i_pix_last  = (k == last_k);
      w = 0;
      while (!bus.o_pix_ready && !abort) begin
        @(posedge clk); #1;
        w++;
        if (w > BOUND) begin
          checks++;
          errors++;
          $display("FAIL ready_timeout pixel %0d ready=%b want 1", k, bus.o_pix_ready);
          abort = 1'b1;
        end
      end
      if (!abort) begin
        @(posedge clk); #1;
        acc_cyc = cyc + 1;
      end
    end
    bus.i_pix_valid = 1'b0;
    bus.i_pix_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_pix_valid = 1'b0;
    bus.i_pix_data = '0;
    bus.i_pix_last = 1'b0;
    bus.i_post_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.o_post_valid !== 1'b0) begin
      errors++; $display("FAIL rst_pv got %b want 0", bus.o_post_valid);
    end
    checks++;
    if (bus.o_frame_err !== 1'b0) begin
      errors++; $display("FAIL rst_err got %b want 0", bus.o_frame_err);
    end
    checks++;
    if (bus.o_data !== '0) begin
      errors++; $display("FAIL rst_data got nonzero want 0");
    end
    checks++;
    if (bus.o_pix_ready !== 1'b0) begin
      errors++; $display("FAIL rst_ready got %b want 0", bus.o_pix_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.o_pix_ready !== 1'b1) begin
      errors++; $display("FAIL post_rst_ready got %b want 1", bus.o_pix_ready);
    end
  endtask

  task automatic test_basic();
    frame_t g, e;
    int d;
    clear_mon();
    bus.i_post_ready = 1'b1;
    exp_q.push_back(mk(0));
    send_frame(NPIX, NPIX - 1, 0);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL basic_count got %0d want 1", got_q.size());
    end
    checks++;
    if (pv_cnt != 1) begin
      errors++; $display("FAIL basic_pv_len got %0d want 1", pv_cnt);
    end
    checks++;
    if (rise_q.size() == 0 || rise_q[0] != acc_cyc) begin
      errors++; $display("FAIL basic_latency got %0d want %0d",
                         (rise_q.size() == 0) ? -1 : rise_q[0], acc_cyc);
    end
    checks++;
    if (err_cnt != 0) begin
      errors++; $display("FAIL basic_err got %0d want 0", err_cnt);
    end
    if (got_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      d = first_diff(g, e);
      checks++;
      if (g !== e) begin
        errors++; $display("FAIL basic_frame px %0d got %0d want %0d",
                           d, g[d/COLS][d%COLS], e[d/COLS][d%COLS]);
      end
      checks++;
      if (g[1][0] !== 8'd28) begin
        errors++; $display("FAIL basic_px_1_0 got %0d want 28", g[1][0]);
      end
      checks++;
      if (g[27][27] !== 8'd15) begin
        errors++; $display("FAIL basic_px_27_27 got %0d want 15", g[27][27]);
      end
    end
  endtask

`ifndef PING_PONG_EN
  task automatic test_hold();
    frame_t g, e;
    clear_mon();
    bus.i_post_ready = 1'b0;
    e = mk(7);
    exp_q.push_back(e);
    send_frame(NPIX, NPIX - 1, 7);
    bus.i_pix_valid = 1'b1;
    bus.i_pix_data  = 8'hAA;
    for (int i = 0; i < 50; i++) begin
      checks++;
      if (bus.o_post_valid !== 1'b1 || bus.o_pix_ready !== 1'b0 || bus.o_data !== e) begin
        errors++;
        $display("FAIL hold_cyc%0d pv=%b ready=%b data_same=%b want 1 0 1",
                 i, bus.o_post_valid, bus.o_pix_ready, bus.o_data === e);
      end
      @(posedge clk); #1;
    end
    bus.i_pix_valid  = 1'b0;
    bus.i_post_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.o_post_valid !== 1'b0) begin
      errors++; $display("FAIL hold_release_pv got %b want 0", bus.o_post_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL hold_count got %0d want 1", got_q.size());
    end
    if (got_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++; $display("FAIL hold_frame px %0d differs", first_diff(g, e));
      end
    end
  endtask
`endif

  task automatic test_early_last();
    frame_t g, e;
    clear_mon();
    bus.i_post_ready = 1'b1;
    send_frame(101, 100, 0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (err_cnt != 1) begin
      errors++; $display("FAIL early_err_len got %0d want 1", err_cnt);
    end
    checks++;
    if (err_cyc != acc_cyc) begin
      errors++; $display("FAIL early_err_time got %0d want %0d", err_cyc, acc_cyc);
    end
    checks++;
    if (pv_cnt != 0) begin
      errors++; $display("FAIL early_no_pv got %0d want 0", pv_cnt);
    end
    exp_q.push_back(mk(50));
    send_frame(NPIX, NPIX - 1, 50);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL early_next_count got %0d want 1", got_q.size());
    end
    if (got_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++; $display("FAIL early_next_frame px %0d differs", first_diff(g, e));
      end
      checks++;
      if (g[0][0] !== 8'd50) begin
        errors++; $display("FAIL early_next_px0 got %0d want 50", g[0][0]);
      end
    end
    checks++;
    if (err_cnt != 1) begin
      errors++; $display("FAIL early_next_err got %0d want 1", err_cnt);
    end
  endtask

  task automatic test_no_last();
    frame_t g, e;
    clear_mon();
    bus.i_post_ready = 1'b1;
    exp_q.push_back(mk(3));
    send_frame(NPIX, -1, 3);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (err_cnt != 1) begin
      errors++; $display("FAIL nolast_err_len got %0d want 1", err_cnt);
    end
    checks++;
    if (rise_q.size() != 1 || err_cyc != acc_cyc || rise_q[0] != acc_cyc) begin
      errors++; $display("FAIL nolast_align err %0d rises %0d want both at %0d",
                         err_cyc, rise_q.size(), acc_cyc);
    end
    if (got_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++; $display("FAIL nolast_frame px %0d differs", first_diff(g, e));
      end
    end
  endtask

  task automatic test_reset_mid();
    frame_t g, e;
    clear_mon();
    bus.i_post_ready = 1'b1;
    send_frame(400, -1, 9);
    rst = 1'b1;
    bus.i_pix_valid = 1'b1;
    bus.i_pix_data  = 8'd99;
    #1;
    checks++;
    if (bus.o_pix_ready !== 1'b0) begin
      errors++; $display("FAIL midrst_ready got %b want 0", bus.o_pix_ready);
    end
    @(posedge clk); #1;
    bus.i_pix_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.o_data !== '0 || bus.o_post_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_state pv=%b data_zero=%b want 0 1",
                         bus.o_post_valid, bus.o_data === '0);
    end
    exp_q.push_back(mk(200));
    send_frame(NPIX, NPIX - 1, 200);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (got_q.size() != 1 || err_cnt != 0) begin
      errors++; $display("FAIL midrst_out frames %0d errs %0d want 1 0",
                         got_q.size(), err_cnt);
    end
    if (got_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++; $display("FAIL midrst_frame px %0d differs", first_diff(g, e));
      end
    end
  endtask

`ifdef PING_PONG_EN
  task automatic test_back_to_back();
    frame_t g, e;
    clear_mon();
    bus.i_post_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      exp_q.push_back(mk(f * 11));
      send_frame(NPIX, NPIX - 1, f * 11);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (stall_cnt != 0) begin
      errors++; $display("FAIL b2b_stall got %0d want 0", stall_cnt);
    end
    checks++;
    if (rise_q.size() != 3) begin
      errors++; $display("FAIL b2b_rises got %0d want 3", rise_q.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (rise_q[i] - rise_q[i-1] != NPIX) begin
          errors++; $display("FAIL b2b_gap%0d got %0d want %0d",
                             i, rise_q[i] - rise_q[i-1], NPIX);
        end
      end
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++; $display("FAIL b2b_frame px %0d differs", first_diff(g, e));
      end
    end
    checks++;
    if (exp_q.size() != 0 || err_cnt != 0) begin
      errors++; $display("FAIL b2b_left exp %0d errs %0d want 0 0",
                         exp_q.size(), err_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
`ifndef PING_PONG_EN
    test_hold();
`endif
    test_early_last();
    test_no_last();
    test_reset_mid();
`ifdef PING_PONG_EN
    test_back_to_back();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
